multi_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point multiplier; next generation of the combinational multi16 (17-bit x 8-bit twiddle multiply) used in the FFT butterfly datapath.
- Adds selectable rounding, output saturation with a flag, a fixed 3-stage pipeline, and valid/ready flow control.
- Sits between the butterfly add/sub stage and the twiddle ROM. One instance per real product.

---
 rtl/multi_pipe_if.sv | 28 ++
 rtl/multi_pipe.sv | 132 +++++++++++++
 tb/tb_multi_pipe.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_pipe_if.sv
// Valid/ready handshake bundle for the pipelined twiddle multiplier.
interface multi_pipe_if #(
    parameter int unsigned A_W   = 17,
    parameter int unsigned B_W   = 8,
    parameter int unsigned OUT_W = 17
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [A_W-1:0]   in_a;
    logic signed [B_W-1:0]   in_b;
    logic                    in_round;
    logic                    out_valid;
    logic                    out_ready;
    logic        [OUT_W-1:0] out_data;
    logic                    out_sat;

    // Producer/consumer side: drives samples, accepts results
    modport master (
        output in_valid, in_a, in_b, in_round, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // Multiplier side
    modport slave (
        input  in_valid, in_a, in_b, in_round, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/multi_pipe.sv
// Three-stage signed fixed-point multiplier with rounding, saturation and
// whole-pipe stall on output backpressure.
module multi_pipe #(
    parameter int unsigned A_W   = 17,
    parameter int unsigned B_W   = 8,
    parameter int unsigned FRAC  = 7,
    parameter int unsigned OUT_W = 17
) (
    input  logic         clk,
    input  logic         rst,
    multi_pipe_if.slave  bus
);
    localparam int unsigned P_W = A_W + B_W;
    localparam int unsigned Q_W = P_W + 1;

    // Clip bounds expressed at the widened quotient width
    localparam logic signed [Q_W-1:0] MAX_Q = {{(Q_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [Q_W-1:0] MIN_Q = {{(Q_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    logic stall_c;

    logic signed [A_W-1:0]   a1_q, a1_d;
    logic signed [B_W-1:0]   b1_q, b1_d;
    logic                    r1_q, r1_d;
    logic                    v1_q, v1_d;

    logic signed [P_W-1:0]   p2_q, p2_d;
    logic                    r2_q, r2_d;
    logic                    v2_q, v2_d;

    logic        [OUT_W-1:0] data_q, data_d;
    logic                    sat_q, sat_d;
    logic                    ov_q, ov_d;

    logic signed [Q_W-1:0]   rnd_c;
    logic signed [Q_W-1:0]   sum_c;
    logic signed [Q_W-1:0]   q_c;

    // A held result freezes every stage, occupied or not
    assign stall_c       = ov_q && !bus.out_ready;
    assign bus.in_ready  = !rst && !stall_c;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = data_q;
    assign bus.out_sat   = sat_q;

    // S1 next state: capture operands and round flag
    always_comb begin
        a1_d = a1_q;
        b1_d = b1_q;
        r1_d = r1_q;
        v1_d = v1_q;
        if (!stall_c) begin
            a1_d = bus.in_a;
            b1_d = bus.in_b;
            r1_d = bus.in_round;
            v1_d = bus.in_valid;
        end
    end

    // S2 next state: full-width signed product
    always_comb begin
        p2_d = p2_q;
        r2_d = r2_q;
        v2_d = v2_q;
        if (!stall_c) begin
            p2_d = P_W'(a1_q) * P_W'(b1_q);
            r2_d = r1_q;
            v2_d = v1_q;
        end
    end

    // S3 arithmetic: one extra bit keeps the rounding add from wrapping
    always_comb begin
        rnd_c = '0;
        if (r2_q) begin
            rnd_c = Q_W'(1) << (FRAC - 1);
        end
        sum_c = Q_W'(p2_q) + rnd_c;
        q_c   = sum_c >>> FRAC;
    end

    // S3 next state: clip to the output range; bubbles leave data untouched
    always_comb begin
        data_d = data_q;
        sat_d  = sat_q;
        ov_d   = ov_q;
        if (!stall_c) begin
            ov_d = v2_q;
            if (v2_q) begin
                if (q_c > MAX_Q) begin
                    data_d = MAX_OUT;
                    sat_d  = 1'b1;
                end else if (q_c < MIN_Q) begin
                    data_d = MIN_OUT;
                    sat_d  = 1'b1;
                end else begin
                    data_d = q_c[OUT_W-1:0];
                    sat_d  = 1'b0;
                end
            end
        end
    end

    // Pipeline registers, synchronously cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q   <= '0;
            b1_q   <= '0;
            r1_q   <= 1'b0;
            v1_q   <= 1'b0;
            p2_q   <= '0;
            r2_q   <= 1'b0;
            v2_q   <= 1'b0;
            data_q <= '0;
            sat_q  <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            r1_q   <= r1_d;
            v1_q   <= v1_d;
            p2_q   <= p2_d;
            r2_q   <= r2_d;
            v2_q   <= v2_d;
            data_q <= data_d;
            sat_q  <= sat_d;
            ov_q   <= ov_d;
        end
    end
endmodule

// File: tb/tb_multi_pipe.sv
// Directed and scoreboarded checks for multi_pipe at default widths and at
// the 16x16 Q15 parameter set.
module tb_multi_pipe;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    multi_pipe_if #(.A_W(17), .B_W(8),  .OUT_W(17)) bus  ();
    multi_pipe_if #(.A_W(16), .B_W(16), .OUT_W(16)) bus2 ();

    multi_pipe #(.A_W(17), .B_W(8), .FRAC(7), .OUT_W(17)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_pipe #(.A_W(16), .B_W(16), .FRAC(15), .OUT_W(16)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer product, optional half-LSB, floor shift, clip
    function automatic logic [17:0] model(input longint a, input longint b,
                                          input bit rnd, input int frac, input int ow);
        longint p;
        longint q;
        longint mx;
        longint mn;
        logic   s;
        p = a * b;
        if (rnd) p = p + (longint'(1) <<< (frac - 1));
        q  = p >>> frac;
        mx = (longint'(1) <<< (ow - 1)) - 1;
        mn = -(longint'(1) <<< (ow - 1));
        s  = 1'b0;
        if (q > mx) begin q = mx; s = 1'b1; end
        else if (q < mn) begin q = mn; s = 1'b1; end
        return {s, 17'(q)};
    endfunction

    task automatic send_one(input logic signed [16:0] a, input logic signed [7:0] b,
                            input logic rnd, output logic [16:0] d, output logic s,
                            output int lat);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_round  = rnd;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.out_data;
        s = bus.out_sat;
        @(posedge clk); #1;
    endtask

    task automatic send_two(input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic rnd, output logic [15:0] d, output logic s,
                            output int lat);
        bus2.in_a      = a;
        bus2.in_b      = b;
        bus2.in_round  = rnd;
        bus2.in_valid  = 1'b1;
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        lat = 1;
        while (!bus2.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus2.out_data;
        s = bus2.out_sat;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.in_round = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_round = 1'b0;
        bus2.out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 17'h0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
        n_vec++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat got=%b want=0", bus.out_sat); end
        rst = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_truncate();
        logic [16:0] d; logic s; int lat;
        send_one(17'sh01108, 8'sh7F, 1'b0, d, s, lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL trunc_latency got=%0d want=3", lat); end
        n_vec++; if (d !== 17'h010E5) begin n_err++; $display("FAIL trunc_data got=%h want=010e5", d); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL trunc_sat got=%b want=0", s); end
    endtask

    task automatic test_round();
        logic [16:0] d; logic s; int lat;
        send_one(17'sh01108, 8'sh7F, 1'b1, d, s, lat);
        n_vec++; if (d !== 17'h010E6) begin n_err++; $display("FAIL round_data got=%h want=010e6", d); end
        send_one(17'sh00100, 8'sh7F, 1'b0, d, s, lat);
        n_vec++; if (d !== 17'h000FE) begin n_err++; $display("FAIL exact_trunc got=%h want=000fe", d); end
        send_one(17'sh00100, 8'sh7F, 1'b1, d, s, lat);
        n_vec++; if (d !== 17'h000FE) begin n_err++; $display("FAIL exact_round got=%h want=000fe", d); end
        // -4360 * 127 = -553720; /128 = -4325.94 -> floor -4326, rounded -4326
        send_one(-17'sd4360, 8'sh7F, 1'b0, d, s, lat);
        n_vec++; if (d !== 17'h1EF1A) begin n_err++; $display("FAIL neg_trunc got=%h want=1ef1a", d); end
    endtask

    task automatic test_saturation();
        logic [16:0] d; logic s; int lat;
        send_one(17'sh10000, 8'sh80, 1'b0, d, s, lat);
        n_vec++; if (d !== 17'h0FFFF) begin n_err++; $display("FAIL sat_pos_data got=%h want=0ffff", d); end
        n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL sat_pos_flag got=%b want=1", s); end
        send_one(17'sh10000, 8'sh80, 1'b1, d, s, lat);
        n_vec++; if (d !== 17'h0FFFF || s !== 1'b1) begin n_err++; $display("FAIL sat_pos_round got=%h/%b want=0ffff/1", d, s); end
        send_one(17'sh0FFFF, 8'sh80, 1'b0, d, s, lat);
        n_vec++; if (d !== 17'h10001) begin n_err++; $display("FAIL nosat_data got=%h want=10001", d); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL nosat_flag got=%b want=0", s); end
    endtask

    task automatic test_alt_params();
        logic [15:0] d; logic s; int lat;
        send_two(16'sh8000, 16'sh8000, 1'b0, d, s, lat);
        n_vec++; if (d !== 16'h7FFF || s !== 1'b1) begin n_err++; $display("FAIL alt_sat got=%h/%b want=7fff/1", d, s); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL alt_latency got=%0d want=3", lat); end
        send_two(16'sh4000, 16'sh4000, 1'b0, d, s, lat);
        n_vec++; if (d !== 16'h2000 || s !== 1'b0) begin n_err++; $display("FAIL alt_half got=%h/%b want=2000/0", d, s); end
        send_two(16'sd3, 16'sh4001, 1'b0, d, s, lat);
        n_vec++; if (d !== 16'h0001) begin n_err++; $display("FAIL alt_trunc got=%h want=0001", d); end
        send_two(16'sd3, 16'sh4001, 1'b1, d, s, lat);
        n_vec++; if (d !== 16'h0002) begin n_err++; $display("FAIL alt_round got=%h want=0002", d); end
    endtask

    task automatic test_backpressure();
        logic [17:0] exp_q[$];
        logic [17:0] e;
        logic [16:0] held;
        bit          held_v;
        int          sent;
        int          got;
        sent = 0; got = 0; held_v = 0; held = '0;
        for (int t = 0; t < 24; t++) begin
            bus.out_ready = !(t >= 5 && t < 9);
            bus.in_valid  = (sent < 8);
            bus.in_a      = 17'(sent * 9001 - 30000);
            bus.in_b      = 8'(sent * 37 - 120);
            bus.in_round  = sent[0];
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                n_vec++;
                if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready t=%0d got=%b want=0", t, bus.in_ready); end
                if (held_v) begin
                    n_vec++;
                    if (bus.out_data !== held) begin n_err++; $display("FAIL bp_hold t=%0d got=%h want=%h", t, bus.out_data, held); end
                end
                held = bus.out_data; held_v = 1;
            end else begin
                held_v = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra got=%h want=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_sat, bus.out_data} !== e) begin n_err++; $display("FAIL bp_data n=%0d got=%h want=%h", got, {bus.out_sat, bus.out_data}, e); end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(longint'(bus.in_a), longint'(bus.in_b), bus.in_round, 7, 17));
                sent++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n_vec++; if (got != 8 || sent != 8) begin n_err++; $display("FAIL bp_count got=%0d sent=%0d want=8", got, sent); end
    endtask

    task automatic test_reset_midstream();
        bit stale;
        for (int t = 0; t < 3; t++) begin
            bus.in_valid = 1'b1; bus.in_a = 17'(1000 + t); bus.in_b = 8'sh40; bus.in_round = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready got=%b want=0", bus.in_ready); end
        @(posedge clk); #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid got=%b want=0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 17'h0) begin n_err++; $display("FAIL mid_rst_out_data got=%h want=0", bus.out_data); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold_ready got=%b want=0", bus.in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_release got=%b want=1", bus.in_ready); end
        stale = 0;
        for (int t = 0; t < 8; t++) begin
            if (bus.out_valid !== 1'b0) stale = 1;
            @(posedge clk); #1;
        end
        n_vec++; if (stale) begin n_err++; $display("FAIL mid_rst_stale got=1 want=0"); end
    endtask

    task automatic test_random();
        logic [17:0] exp_q[$];
        logic [17:0] e;
        int          got;
        int          acc;
        got = 0; acc = 0;
        for (int t = 0; t < 1600; t++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            bus.in_round  = 1'($urandom);
            case ($urandom_range(7))
                0: begin bus.in_a = 17'sh10000; bus.in_b = 8'sh80; end
                1: begin bus.in_a = 17'sh0FFFF; bus.in_b = 8'sh80; end
                default: begin bus.in_a = 17'($urandom); bus.in_b = 8'($urandom); end
            endcase
            if (t >= 1580) begin bus.in_valid = 1'b0; bus.out_ready = 1'b1; end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL rnd_extra got=%h want=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if ({bus.out_sat, bus.out_data} !== e) begin n_err++; $display("FAIL rnd_data n=%0d got=%h want=%h", got, {bus.out_sat, bus.out_data}, e); end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(longint'(bus.in_a), longint'(bus.in_b), bus.in_round, 7, 17));
                acc++;
            end
            @(posedge clk); #1;
        end
        n_vec++; if (got != acc || exp_q.size() != 0) begin n_err++; $display("FAIL rnd_drain got=%0d want=%0d", got, acc); end
    endtask

    initial begin
        test_reset();
        test_truncate();
        test_round();
        test_saturation();
        test_alt_params();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
